// File: rtl/onehot_bit_walker_if.sv
// rtl/onehot_bit_walker_if.sv - mask-in / one-hot-out handshake bundle for onehot_bit_walker
interface onehot_bit_walker_if #(
  parameter int Width    = 32,
  parameter int IdxWidth = $clog2(Width)
);
  logic [Width-1:0]    mask;
  logic                mask_valid;
  logic                mask_ready;
  logic [Width-1:0]    onehot;
  logic [IdxWidth-1:0] idx;
  logic                last;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output mask, mask_valid, out_ready,
    input  mask_ready, onehot, idx, last, out_valid
  );

  modport slave (
    input  mask, mask_valid, out_ready,
    output mask_ready, onehot, idx, last, out_valid
  );
endinterface

// File: rtl/onehot_bit_walker.sv
// rtl/onehot_bit_walker.sv - serialises a multi-bit mask into LSB-first one-hot beats
// One mask in flight at a time; clear_i aborts the walk without a done pulse.
module onehot_bit_walker #(
  parameter int Width    = 32,
  parameter int IdxWidth = $clog2(Width),
  parameter int CntWidth = $clog2(Width + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  onehot_bit_walker_if.slave   bus,
  output logic                 done_o,
  output logic                 busy_o,
  output logic [CntWidth-1:0]  count_o
);

  typedef enum logic {IDLE, WALK} state_e;

  state_e              state_q, state_d;
  logic [Width-1:0]    pending_q, pending_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic                done_q, done_d;

  logic [Width-1:0]    lowbit;
  logic [IdxWidth-1:0] low_idx;
  logic                single;

  // Two's-complement trick isolates the lowest set bit; x & (x-1) == 0 means one bit left.
  assign lowbit = pending_q & (~pending_q + Width'(1));
  assign single = ((pending_q & (pending_q - Width'(1))) == '0);

  always_comb begin
    low_idx = '0;
    for (int i = 0; i < Width; i++) begin
      if (lowbit[i]) low_idx = IdxWidth'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.mask_valid) begin
          pending_d = bus.mask;
          count_d   = '0;
          if (bus.mask != '0) state_d = WALK;
          else                done_d  = 1'b1;
        end
      end
      WALK: begin
        if (bus.out_ready) begin
          pending_d = pending_q & ~lowbit;
          count_d   = count_q + CntWidth'(1);
          if (single) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear_i) begin
      state_d   = IDLE;
      pending_d = '0;
      count_d   = count_q;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pending_q <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      done_q    <= done_d;
    end
  end

  assign bus.mask_ready = (state_q == IDLE);
  assign bus.out_valid  = (state_q == WALK);
  assign bus.onehot     = (state_q == WALK) ? lowbit : '0;
  assign bus.idx        = (state_q == WALK) ? low_idx : '0;
  assign bus.last       = (state_q == WALK) && single;
  assign done_o         = done_q;
  assign busy_o         = (state_q != IDLE);
  assign count_o        = count_q;

endmodule

// File: tb/tb_onehot_bit_walker.sv
// tb/tb_onehot_bit_walker.sv - scoreboard bench for onehot_bit_walker
module tb_onehot_bit_walker;
  localparam int Width    = 32;
  localparam int IdxWidth = 5;
  localparam int CntWidth = 6;

  typedef struct packed {
    logic [Width-1:0]    onehot;
    logic [IdxWidth-1:0] idx;
    logic                last;
  } beat_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                clear = 1'b0;
  logic                done;
  logic                busy;
  logic [CntWidth-1:0] count;

  int    tests = 0;
  int    fails = 0;
  beat_t sb[$];
  beat_t held;
  bit    have_held = 1'b0;

  onehot_bit_walker_if #(.Width(Width), .IdxWidth(IdxWidth)) bus ();

  onehot_bit_walker #(.Width(Width), .IdxWidth(IdxWidth), .CntWidth(CntWidth)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (clear),
    .bus     (bus),
    .done_o  (done),
    .busy_o  (busy),
    .count_o (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input bit last);
    beat_t b;
    b.onehot = Width'(1) << idx;
    b.idx    = IdxWidth'(idx);
    b.last   = last;
    sb.push_back(b);
  endtask

  // Monitor: pops on every accepted beat and checks stalled beats hold stable.
  always @(negedge clk) begin
    beat_t cur, e;
    cur = '{onehot: bus.onehot, idx: bus.idx, last: bus.last};
    if (!rst_n || clear || !bus.out_valid) begin
      have_held = 1'b0;
    end else begin
      if (have_held) check("stall_hold", 64'(cur), 64'(held));
      if (bus.out_ready) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_beat: got idx %0d expected no beat", cur.idx);
        end else begin
          e = sb.pop_front();
          check("beat_onehot", 64'(cur.onehot), 64'(e.onehot));
          check("beat_idx", 64'(cur.idx), 64'(e.idx));
          check("beat_last", 64'(cur.last), 64'(e.last));
        end
        have_held = 1'b0;
      end else begin
        held      = cur;
        have_held = 1'b1;
      end
    end
  end

  // Presents one mask, then runs until done_o; mode 1 stalls with ready 1,0,0,...
  task automatic run_mask(input logic [Width-1:0] m, input int mode, input int exp_cnt,
                          input int exp_wait);
    int waits;
    check("mask_ready_at_accept", 64'(bus.mask_ready), 64'd1);
    bus.mask       = m;
    bus.mask_valid = 1'b1;
    @(posedge clk); #1;
    bus.mask_valid = 1'b0;
    waits = 0;
    while (!done && waits < 300) begin
      bus.out_ready = (mode == 0) ? 1'b1 : ((waits % 3) == 0);
      @(posedge clk); #1;
      waits++;
    end
    bus.out_ready = 1'b1;
    if (!done) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", waits);
    end else begin
      check("done_count", 64'(count), 64'(exp_cnt));
      check("sb_drained_at_done", 64'(sb.size()), 64'd0);
      if (exp_wait >= 0) check("done_latency", 64'(waits), 64'(exp_wait));
    end
  endtask

  task automatic check_pulse_end();
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);
    check("idle_after_done", 64'(busy), 64'd0);
  endtask

  task automatic push_aaee();
    push(1, 0); push(2, 0); push(3, 0); push(5, 0); push(6, 0);
    push(7, 0); push(9, 0); push(11, 0); push(13, 0); push(15, 1);
  endtask

  initial begin
    bus.mask       = '0;
    bus.mask_valid = 1'b0;
    bus.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_ready", 64'(bus.mask_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_onehot", 64'(bus.onehot), 64'd0);
    check("rst_idx", 64'(bus.idx), 64'd0);
    check("rst_last", 64'(bus.last), 64'd0);

    push_aaee();
    run_mask(32'd43758, 0, 10, 10);
    check_pulse_end();

    push_aaee();
    run_mask(32'd43758, 1, 10, -1);
    check_pulse_end();

    run_mask(32'd0, 0, 0, 0);
    check("zero_mask_ready", 64'(bus.mask_ready), 64'd1);
    check_pulse_end();

    for (int i = 0; i < 32; i++) push(i, i == 31);
    run_mask(32'hFFFF_FFFF, 0, 32, 32);
    check_pulse_end();

    // Second mask is offered in the same cycle done_o is high.
    push(5, 0); push(12, 1);
    run_mask(32'd4096 | 32'd32, 0, 2, 2);
    push(0, 0); push(1, 1);
    run_mask(32'h3, 0, 2, 2);
    check_pulse_end();

    push(5, 0); push(12, 1);
    bus.mask = 32'd4096 | 32'd32;
    bus.mask_valid = 1'b1;
    @(posedge clk); #1;
    bus.mask_valid = 1'b0;
    check("clr_beat1_idx", 64'(bus.idx), 64'd5);
    clear = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    sb.delete();
    check("clr_valid", 64'(bus.out_valid), 64'd0);
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_done", 64'(done), 64'd0);
    check("clr_count", 64'(count), 64'd0);
    @(posedge clk); #1;
    check("clr_no_late_done", 64'(done), 64'd0);

    push_aaee();
    bus.mask = 32'd43758;
    bus.mask_valid = 1'b1;
    @(posedge clk); #1;
    bus.mask_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_count", 64'(count), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus.out_valid), 64'd0);
    check("arst_ready", 64'(bus.mask_ready), 64'd1);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_onehot", 64'(bus.onehot), 64'd0);
    check("arst_idx", 64'(bus.idx), 64'd0);
    check("arst_last", 64'(bus.last), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", 64'(bus.out_valid), 64'd0);

    check("sb_empty_end", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
